// File: rtl/snes_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : snes_pkg
//  Description : Shared constants, FSM state encoding and helper function for
//                the SNES controller poll scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
package snes_pkg;

    localparam int NUM_CTRL   = 4;
    localparam int BTN_W      = 12;
    localparam int CTRL_IDX_W = 2;
    localparam int RSP_W      = 2 * BTN_W;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RD     = 2'd1,
        ST_CAP    = 2'd2,
        ST_UPDATE = 2'd3
    } poll_state_t;

    // Buttons that went from released to pressed between two scans.
    function automatic logic [BTN_W-1:0] rise_edges(
        input logic [BTN_W-1:0] new_btn,
        input logic [BTN_W-1:0] old_btn
    );
        return new_btn & ~old_btn;
    endfunction

endpackage
`default_nettype wire

// File: rtl/snes_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : snes_rr_arbiter
//  Description : Round-robin selector. Searches from pointer+1 (wrapping) for
//                the first asserted request; the pointer follows every
//                selection without waiting for an acknowledge.
//  Revision    : 1.0 - initial release
// ============================================================================
module snes_rr_arbiter #(
    parameter int NUM_REQ = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [NUM_REQ-1:0]         req_i,
    output logic [NUM_REQ-1:0]         sel_oh_o,
    output logic [$clog2(NUM_REQ)-1:0] nxt_ptr_o,
    output logic                       sel_valid_o
);

    localparam int IDX_W = $clog2(NUM_REQ);

    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] ptr_d;
    logic [IDX_W-1:0] w_cand;
    logic             w_found;

    // First asserted request after the pointer, wrapping modulo NUM_REQ.
    always_comb begin
        w_found = 1'b0;
        w_cand  = '0;
        ptr_d   = ptr_q;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_cand = IDX_W'((int'(ptr_q) + k) % NUM_REQ);
            if (!w_found && req_i[w_cand]) begin
                w_found = 1'b1;
                ptr_d   = w_cand;
            end
        end
    end

    assign sel_valid_o = w_found;
    assign nxt_ptr_o   = ptr_d;

    // One-hot form of the winning index.
    always_comb begin
        sel_oh_o = '0;
        if (w_found) begin
            sel_oh_o[ptr_d] = 1'b1;
        end
    end

    // Pointer register: moves to the winner on every selection.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/snes_poll_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : snes_poll_scheduler
//  Description : Periodically scans the four SNES controller ports, keeps
//                shadow button words and per-requester sticky "newly pressed"
//                flags, and serves them to NUM_REQ clients via round-robin
//                req/gnt. Optional change interrupt: SNES_CHANGE_IRQ_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module snes_poll_scheduler
    import snes_pkg::*;
#(
    parameter int POLL_PERIOD = 208333,
    parameter int NUM_REQ     = 2
) (
    input  logic                         sys_clk,
    input  logic                         sys_reset,
    output logic                         snes_read_enable,
    output logic [CTRL_IDX_W-1:0]        snes_address,
    input  logic [BTN_W-1:0]             snes_read_data,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [CTRL_IDX_W*NUM_REQ-1:0] req_ctrl,
    output logic [NUM_REQ-1:0]           gnt,
    output logic                         rsp_valid,
    output logic [RSP_W-1:0]             rsp_data,
    output logic                         poll_done,
    output logic                         change_irq
);

    localparam int CNT_W = $clog2(POLL_PERIOD);
    localparam int IDX_W = $clog2(NUM_REQ);

    // ------------------------------------------------------------------
    // Period counter
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             w_wrap;

    assign w_wrap = (cnt_q == CNT_W'(POLL_PERIOD - 1));
    assign cnt_d  = w_wrap ? '0 : cnt_q + 1'b1;

    // Free-running period counter, independent of the scan FSM.
    always_ff @(posedge sys_clk or posedge sys_reset) begin
        if (sys_reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Scan FSM
    // ------------------------------------------------------------------
    poll_state_t           state_q, state_d;
    logic [CTRL_IDX_W-1:0] idx_q, idx_d;
    logic                  rd_en_q, rd_en_d;
    logic [CTRL_IDX_W-1:0] addr_q, addr_d;
    logic                  done_q, done_d;

    // Next state plus next values of the registered interface outputs.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        rd_en_d = 1'b0;
        addr_d  = '0;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (w_wrap) begin
                    state_d = ST_RD;
                    idx_d   = '0;
                end
            end
            ST_RD: begin
                state_d = ST_CAP;
            end
            ST_CAP: begin
                if (idx_q == CTRL_IDX_W'(NUM_CTRL - 1)) begin
                    state_d = ST_UPDATE;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = ST_RD;
                end
            end
            ST_UPDATE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (state_d == ST_RD) begin
            rd_en_d = 1'b1;
            addr_d  = idx_d;
        end
        done_d = (state_d == ST_UPDATE);
    end

    // State register and registered strobe/address/done outputs.
    always_ff @(posedge sys_clk or posedge sys_reset) begin
        if (sys_reset) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            rd_en_q <= 1'b0;
            addr_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            rd_en_q <= rd_en_d;
            addr_q  <= addr_d;
            done_q  <= done_d;
        end
    end

    assign snes_read_enable = rd_en_q;
    assign snes_address     = addr_q;
    assign poll_done        = done_q;

    // ------------------------------------------------------------------
    // Shadow button registers
    // ------------------------------------------------------------------
    logic [BTN_W-1:0] new_btn_q [NUM_CTRL];
    logic [BTN_W-1:0] btn_q     [NUM_CTRL];

    // Collect the four scan words, then commit them together in UPDATE.
    always_ff @(posedge sys_clk or posedge sys_reset) begin
        if (sys_reset) begin
            for (int c = 0; c < NUM_CTRL; c++) begin
                new_btn_q[c] <= '0;
                btn_q[c]     <= '0;
            end
        end else begin
            if (state_q == ST_CAP) begin
                new_btn_q[idx_q] <= snes_read_data;
            end
            if (state_q == ST_UPDATE) begin
                for (int c = 0; c < NUM_CTRL; c++) begin
                    btn_q[c] <= new_btn_q[c];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Arbitration and response
    // ------------------------------------------------------------------
    logic [NUM_REQ-1:0]    gnt_q;
    logic [IDX_W-1:0]      gidx_q;
    logic [CTRL_IDX_W-1:0] gctrl_q;
    logic [NUM_REQ-1:0]    w_sel_oh;
    logic [IDX_W-1:0]      w_sel_idx;
    logic                  w_sel_valid;
    logic [NUM_REQ-1:0]    w_req_masked;

    // The requester holding the grant sits out this cycle's arbitration.
    assign w_req_masked = req & ~gnt_q;

    snes_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .clk_i       (sys_clk),
        .rst_i       (sys_reset),
        .req_i       (w_req_masked),
        .sel_oh_o    (w_sel_oh),
        .nxt_ptr_o   (w_sel_idx),
        .sel_valid_o (w_sel_valid)
    );

    // Grant register; the controller index is captured at selection time.
    always_ff @(posedge sys_clk or posedge sys_reset) begin
        if (sys_reset) begin
            gnt_q   <= '0;
            gidx_q  <= '0;
            gctrl_q <= '0;
        end else begin
            gnt_q <= w_sel_oh;
            if (w_sel_valid) begin
                gidx_q  <= w_sel_idx;
                gctrl_q <= req_ctrl[{w_sel_idx, 1'b0} +: CTRL_IDX_W];
            end
        end
    end

    // ------------------------------------------------------------------
    // Sticky pressed flags
    // ------------------------------------------------------------------
    logic [BTN_W-1:0] pressed_q [NUM_REQ][NUM_CTRL];
    logic [BTN_W-1:0] pressed_d [NUM_REQ][NUM_CTRL];
    logic [BTN_W-1:0] w_edge    [NUM_CTRL];

    // New edges OR in on UPDATE; a grant clears its entry, but an edge
    // arriving in the same cycle survives the clear.
    always_comb begin
        for (int c = 0; c < NUM_CTRL; c++) begin
            w_edge[c] = (state_q == ST_UPDATE) ? rise_edges(new_btn_q[c], btn_q[c]) : '0;
        end
        for (int r = 0; r < NUM_REQ; r++) begin
            for (int c = 0; c < NUM_CTRL; c++) begin
                if (gnt_q[r] && (gctrl_q == CTRL_IDX_W'(c))) begin
                    pressed_d[r][c] = w_edge[c];
                end else begin
                    pressed_d[r][c] = pressed_q[r][c] | w_edge[c];
                end
            end
        end
    end

    // Pressed-flag storage.
    always_ff @(posedge sys_clk or posedge sys_reset) begin
        if (sys_reset) begin
            for (int r = 0; r < NUM_REQ; r++) begin
                for (int c = 0; c < NUM_CTRL; c++) begin
                    pressed_q[r][c] <= '0;
                end
            end
        end else begin
            pressed_q <= pressed_d;
        end
    end

    // Response mux reads pre-update values during the grant cycle.
    assign gnt       = gnt_q;
    assign rsp_valid = |gnt_q;
    assign rsp_data  = rsp_valid ? {pressed_q[gidx_q][gctrl_q], btn_q[gctrl_q]} : '0;

    // ------------------------------------------------------------------
    // Change interrupt
    // ------------------------------------------------------------------
`ifdef SNES_CHANGE_IRQ_EN
    logic irq_q;
    logic w_any_change;

    // Any controller word differs from its shadow.
    always_comb begin
        w_any_change = 1'b0;
        for (int c = 0; c < NUM_CTRL; c++) begin
            if (new_btn_q[c] != btn_q[c]) begin
                w_any_change = 1'b1;
            end
        end
    end

    // Level set by a changing UPDATE, cleared after any grant; set wins.
    always_ff @(posedge sys_clk or posedge sys_reset) begin
        if (sys_reset) begin
            irq_q <= 1'b0;
        end else if ((state_q == ST_UPDATE) && w_any_change) begin
            irq_q <= 1'b1;
        end else if (|gnt_q) begin
            irq_q <= 1'b0;
        end
    end

    assign change_irq = irq_q;
`else
    assign change_irq = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_snes_poll_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_snes_poll_scheduler
//  Description : Directed self-checking bench for snes_poll_scheduler with
//                POLL_PERIOD=16, NUM_REQ=2 and a registered SNES interface
//                model. Cycle n is the interval after the n-th rising edge
//                following reset release; outputs are sampled on falling edges.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_snes_poll_scheduler;

`ifdef SNES_CHANGE_IRQ_EN
    localparam logic IRQ_EN = 1'b1;
`else
    localparam logic IRQ_EN = 1'b0;
`endif

    logic        sys_clk = 1'b0;
    logic        sys_reset;
    logic        snes_read_enable;
    logic [1:0]  snes_address;
    logic [11:0] snes_read_data;
    logic [1:0]  req;
    logic [3:0]  req_ctrl;
    logic [1:0]  gnt;
    logic        rsp_valid;
    logic [23:0] rsp_data;
    logic        poll_done;
    logic        change_irq;

    logic [11:0] tbl [4];
    int          cyc;
    int          n_assert;
    int          n_fail;

    snes_poll_scheduler #(
        .POLL_PERIOD (16),
        .NUM_REQ     (2)
    ) dut (
        .sys_clk          (sys_clk),
        .sys_reset        (sys_reset),
        .snes_read_enable (snes_read_enable),
        .snes_address     (snes_address),
        .snes_read_data   (snes_read_data),
        .req              (req),
        .req_ctrl         (req_ctrl),
        .gnt              (gnt),
        .rsp_valid        (rsp_valid),
        .rsp_data         (rsp_data),
        .poll_done        (poll_done),
        .change_irq       (change_irq)
    );

    always #5 sys_clk = ~sys_clk;

    // SNES interface model: returns the addressed word one cycle after the strobe.
    always @(posedge sys_clk or posedge sys_reset) begin
        if (sys_reset) begin
            snes_read_data <= '0;
        end else if (snes_read_enable) begin
            snes_read_data <= tbl[snes_address];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge sys_clk);
        cyc++;
    endtask

    task automatic goto(input int c);
        while (cyc < c) step();
    endtask

    // Single request: raise req, expect the grant one cycle later, drop req.
    task automatic rd(input int r, input logic [1:0] c, input logic [23:0] exp, input string tag);
        req_ctrl[2*r +: 2] = c;
        req[r] = 1'b1;
        step();
        chk({tag, "_gnt"}, 32'(gnt), 32'(2'b01 << r));
        chk({tag, "_vld"}, 32'(rsp_valid), 32'd1);
        chk({tag, "_data"}, 32'(rsp_data), 32'(exp));
        req[r] = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_re"},   32'(snes_read_enable), 32'd0);
        chk({tag, "_addr"}, 32'(snes_address), 32'd0);
        chk({tag, "_gnt"},  32'(gnt), 32'd0);
        chk({tag, "_vld"},  32'(rsp_valid), 32'd0);
        chk({tag, "_data"}, 32'(rsp_data), 32'd0);
        chk({tag, "_done"}, 32'(poll_done), 32'd0);
        chk({tag, "_irq"},  32'(change_irq), 32'd0);
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        cyc      = 0;
        req      = '0;
        req_ctrl = '0;
        tbl[0] = 12'h00A; tbl[1] = 12'h0B0; tbl[2] = 12'hC00; tbl[3] = 12'h001;
        sys_reset = 1'b1;
        @(negedge sys_clk);
        @(negedge sys_clk);
        chk_all_zero("reset");
        sys_reset = 1'b0;
        cyc = 0;

        // First poll: strobes at 16,18,20,22 with addresses 0..3, done at 24.
        for (int c = 1; c <= 25; c++) begin
            logic re_e;
            step();
            re_e = (c >= 16) && (c <= 22) && (c % 2 == 0);
            chk($sformatf("p1_re_c%0d", c), 32'(snes_read_enable), 32'(re_e));
            chk($sformatf("p1_addr_c%0d", c), 32'(snes_address), re_e ? 32'((c - 16) / 2) : 32'd0);
            chk($sformatf("p1_done_c%0d", c), 32'(poll_done), 32'(c == 24));
            chk($sformatf("p1_irq_c%0d", c), 32'(change_irq), 32'(IRQ_EN && (c == 25)));
        end

        // Shadows after the first poll; every bit is newly pressed.
        tbl[0] = 12'h000;
        rd(0, 2'd0, {12'h00A, 12'h00A}, "r0c0_a"); step();
        chk("irq_clr_after_gnt", 32'(change_irq), 32'd0);
        rd(0, 2'd1, {12'h0B0, 12'h0B0}, "r0c1_a"); step();
        rd(0, 2'd2, {12'hC00, 12'hC00}, "r0c2_a"); step();
        rd(0, 2'd3, {12'h001, 12'h001}, "r0c3_a"); step();
        rd(0, 2'd0, {12'h000, 12'h00A}, "r0c0_b"); step();
        rd(1, 2'd0, {12'h00A, 12'h00A}, "r1c0_a"); step();

        // Poll 2 sees ctrl 0 released, poll 3 sees 0x005.
        goto(41);
        tbl[0] = 12'h005;
        goto(57);
        chk("irq_set_p3", 32'(change_irq), 32'(IRQ_EN));
        rd(0, 2'd0, {12'h005, 12'h005}, "r0c0_p3a"); step();
        chk("irq_clr_p3", 32'(change_irq), 32'd0);
        rd(0, 2'd0, {12'h000, 12'h005}, "r0c0_p3b"); step();
        rd(1, 2'd0, {12'h005, 12'h005}, "r1c0_p3"); step();

        // Both requests held: pointer is 1, so grants go 01,10,01,...
        req_ctrl = {2'd2, 2'd1};
        req      = 2'b11;
        for (int k = 0; k < 6; k++) begin
            step();
            if (k % 2 == 0) begin
                chk($sformatf("alt_gnt_%0d", k), 32'(gnt), 32'h1);
                chk($sformatf("alt_data_%0d", k), 32'(rsp_data), 32'({12'h000, 12'h0B0}));
            end else begin
                chk($sformatf("alt_gnt_%0d", k), 32'(gnt), 32'h2);
                chk($sformatf("alt_data_%0d", k), 32'(rsp_data),
                    (k == 1) ? 32'({12'hC00, 12'hC00}) : 32'({12'h000, 12'hC00}));
            end
        end
        req = 2'b00;
        step();
        chk("alt_idle_gnt", 32'(gnt), 32'd0);
        chk("alt_idle_vld", 32'(rsp_valid), 32'd0);

        // Grant of r0/ctrl1 lands on the UPDATE cycle that sets bit 11.
        tbl[1] = 12'h8B0;
        goto(87);
        rd(0, 2'd1, {12'h000, 12'h0B0}, "coll_gnt");
        chk("coll_done", 32'(poll_done), 32'd1);
        step();
        rd(0, 2'd1, {12'h800, 12'h8B0}, "coll_after"); step();
        rd(1, 2'd1, {12'h8B0, 12'h8B0}, "coll_r1"); step();

        // Reset asserted during CAP of index 2 while a grant is active.
        goto(100);
        chk("p6_re_rd2", 32'(snes_read_enable), 32'd1);
        chk("p6_addr_rd2", 32'(snes_address), 32'd2);
        req_ctrl[3:2] = 2'd0;
        req[1] = 1'b1;
        step();
        chk("p6_cap2_re", 32'(snes_read_enable), 32'd0);
        chk("p6_cap2_gnt", 32'(gnt), 32'h2);
        chk("p6_cap2_data", 32'(rsp_data), 32'({12'h000, 12'h005}));
        sys_reset = 1'b1;
        req = 2'b00;
        #1;
        chk_all_zero("midrst");
        step();
        step();
        sys_reset = 1'b0;
        cyc = 0;

        // Shadows and flags cleared; next poll 16 cycles after release.
        step();
        rd(0, 2'd1, {12'h000, 12'h000}, "post_rst"); step();
        goto(15);
        chk("post_re_c15", 32'(snes_read_enable), 32'd0);
        step();
        chk("post_re_c16", 32'(snes_read_enable), 32'd1);
        chk("post_addr_c16", 32'(snes_address), 32'd0);
        step();
        chk("post_re_c17", 32'(snes_read_enable), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
